// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered command front-end and result back-end for the
// 8-bit ALU datapath. Latches one operation per handshake, waits SETTLE_CYCLES
// for the combinational ALU result, then offers it downstream.
// Optional build macro ALU_SEQ_FLAGS_EN adds registered zero/negative flags.
module alu_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_x,
   input  logic [7:0]  in_y,
   input  logic [1:0]  in_m,
   input  logic [1:0]  in_s,
   output logic [7:0]  alu_x,
   output logic [7:0]  alu_y,
   output logic [1:0]  alu_m,
   output logic [1:0]  alu_s,
   input  logic [15:0] alu_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_z,
   output logic [1:0]  out_m,
`ifdef ALU_SEQ_FLAGS_EN
   output logic [1:0]  out_s,
   output logic        out_zero,
   output logic        out_neg
`else
   output logic [1:0]  out_s
`endif
);

   localparam int unsigned CW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned ZW = 16;

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   ax_q, ax_d, ay_q, ay_d;
   logic [1:0]      am_q, am_d, as_q, as_d;
   logic [ZW-1:0]   oz_q, oz_d;
   logic [1:0]      om_q, om_d, os_q, os_d;
   logic            ov_q, ov_d;
   logic            accept;
`ifdef ALU_SEQ_FLAGS_EN
   logic            zero_q, zero_d, neg_q, neg_d;
`endif

   // Ready depends only on state and downstream ready so it never loops back through in_valid.
   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   // Next-state, operand load, counter and result capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ax_d    = ax_q;
      ay_d    = ay_q;
      am_d    = am_q;
      as_d    = as_q;
      oz_d    = oz_q;
      om_d    = om_q;
      os_d    = os_q;
      ov_d    = ov_q;
`ifdef ALU_SEQ_FLAGS_EN
      zero_d  = zero_q;
      neg_d   = neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               ax_d    = in_x;
               ay_d    = in_y;
               am_d    = in_m;
               as_d    = in_s;
               cnt_d   = CW'(SETTLE_CYCLES - 1);
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               oz_d    = alu_z;
               om_d    = am_q;
               os_d    = as_q;
               ov_d    = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
               zero_d  = (alu_z == '0);
               neg_d   = alu_z[ZW-1];
`endif
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_d = 1'b0;
               if (accept) begin
                  ax_d    = in_x;
                  ay_d    = in_y;
                  am_d    = in_m;
                  as_d    = in_s;
                  cnt_d   = CW'(SETTLE_CYCLES - 1);
                  state_d = SETTLE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ax_q    <= '0;
         ay_q    <= '0;
         am_q    <= '0;
         as_q    <= '0;
         oz_q    <= '0;
         om_q    <= '0;
         os_q    <= '0;
         ov_q    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
         zero_q  <= 1'b1;
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
         am_q    <= am_d;
         as_q    <= as_d;
         oz_q    <= oz_d;
         om_q    <= om_d;
         os_q    <= os_d;
         ov_q    <= ov_d;
`ifdef ALU_SEQ_FLAGS_EN
         zero_q  <= zero_d;
         neg_q   <= neg_d;
`endif
      end
   end

   assign alu_x     = ax_q;
   assign alu_y     = ay_q;
   assign alu_m     = am_q;
   assign alu_s     = as_q;
   assign out_z     = oz_q;
   assign out_m     = om_q;
   assign out_s     = os_q;
   assign out_valid = ov_q;
`ifdef ALU_SEQ_FLAGS_EN
   assign out_zero  = zero_q;
   assign out_neg   = neg_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: ALU model, result scoreboard, directed steps.
// Flag checks compile only when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_op_sequencer;

   typedef struct packed {
      logic [15:0] z;
      logic [1:0]  m;
      logic [1:0]  s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  in_x, in_y, alu_x, alu_y;
   logic [1:0]  in_m, in_s, alu_m, alu_s, out_m, out_s;
   logic [15:0] alu_z, out_z;
   logic        ov_en;
   logic [15:0] ov_val;

   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [7:0]  alu_x_b, alu_y_b;
   logic [1:0]  alu_m_b, alu_s_b, out_m_b, out_s_b;
   logic [15:0] zb, out_z_b;
`ifdef ALU_SEQ_FLAGS_EN
   logic        out_zero, out_neg, out_zero_b, out_neg_b;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_cnt = 0;
   int   acc0;
   bit   ok;
   bit   ov_prev = 1'b0;
   exp_t sb[$];
   int   rise_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [15:0] alu_model(logic [7:0] x, logic [7:0] y,
                                             logic [1:0] m, logic [1:0] s);
      if (m == 2'b11) begin
         case (s)
            2'b00:   return {8'h00, x & y};
            2'b01:   return {8'h00, x | y};
            2'b10:   return {8'h00, x ^ y};
            default: return {8'h00, ~x};
         endcase
      end
      return {8'h00, x} + {8'h00, y};
   endfunction

   assign alu_z = ov_en ? ov_val : alu_model(alu_x, alu_y, alu_m, alu_s);

   alu_op_sequencer #(.SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_m(in_m), .in_s(in_s),
      .alu_x(alu_x), .alu_y(alu_y), .alu_m(alu_m), .alu_s(alu_s),
      .alu_z(alu_z), .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_m(out_m),
`ifdef ALU_SEQ_FLAGS_EN
      .out_s(out_s), .out_zero(out_zero), .out_neg(out_neg)
`else
      .out_s(out_s)
`endif
   );

   alu_op_sequencer #(.SETTLE_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_x(8'h01), .in_y(8'h02), .in_m(2'b00), .in_s(2'b01),
      .alu_x(alu_x_b), .alu_y(alu_y_b), .alu_m(alu_m_b), .alu_s(alu_s_b),
      .alu_z(zb), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_z(out_z_b), .out_m(out_m_b),
`ifdef ALU_SEQ_FLAGS_EN
      .out_s(out_s_b), .out_zero(out_zero_b), .out_neg(out_neg_b)
`else
      .out_s(out_s_b)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   // Scoreboard: push on input handshake, pop/compare on output handshake.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            check("sb_underflow", 32'(sb.size() == 0), 32'd0);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("sb_out_z", 32'(out_z), 32'(e.z));
               check("sb_out_m", 32'(out_m), 32'(e.m));
               check("sb_out_s", 32'(out_s), 32'(e.s));
            end
         end
         if (in_valid && in_ready)
            sb.push_back('{z: (ov_en ? ov_val : alu_model(in_x, in_y, in_m, in_s)),
                           m: in_m, s: in_s});
         if (out_valid && !ov_prev) rise_q.push_back(edge_cnt);
      end
      ov_prev = out_valid;
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_x = '0; in_y = '0; in_m = '0; in_s = '0;
      ov_en = 1'b0; ov_val = '0;
      in_valid_b = 1'b0; out_ready_b = 1'b0; zb = '0;
      repeat (2) cyc();
      rst = 1'b0;

      // Reset values
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_z", 32'(out_z), 32'd0);
      check("rst_out_ms", 32'({out_m, out_s}), 32'd0);
      check("rst_alu", 32'({alu_x, alu_y, alu_m, alu_s}), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
      check("rst_flags", 32'({out_zero, out_neg}), 32'b10);
`endif

      // Single logic-unit AND op
      cyc();
      in_x = 8'hF0; in_y = 8'h3C; in_m = 2'b11; in_s = 2'b00; in_valid = 1'b1;
      wait_ready(ok);
      check("t1_accept_timeout", 32'(ok), 32'd1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("t1_alu_x", 32'(alu_x), 32'hF0);
      check("t1_alu_y", 32'(alu_y), 32'h3C);
      check("t1_alu_ms", 32'({alu_m, alu_s}), 32'b1100);
      check("t1_in_ready_settle", 32'(in_ready), 32'd0);
      repeat (3) cyc();
      @(negedge clk);
      check("t1_valid_early", 32'(out_valid), 32'd0);
      cyc();
      in_x = 8'h55; in_y = 8'hAA; in_m = 2'b01; in_s = 2'b10; in_valid = 1'b1;
      @(negedge clk);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_out_z", 32'(out_z), 32'h0030);
      check("t1_out_m", 32'(out_m), 32'b11);
`ifdef ALU_SEQ_FLAGS_EN
      check("t1_zero", 32'(out_zero), 32'd0);
      check("t1_neg", 32'(out_neg), 32'd0);
`endif

      // Backpressure in DONE with a pending command
      repeat (10) begin
         cyc();
         @(negedge clk);
         check("t2_out_z_hold", 32'(out_z), 32'h0030);
         check("t2_valid_hold", 32'(out_valid), 32'd1);
         check("t2_in_ready", 32'(in_ready), 32'd0);
         check("t2_alu_x", 32'(alu_x), 32'hF0);
         check("t2_alu_ms", 32'({alu_m, alu_s}), 32'b1100);
      end
      cyc();
      out_ready = 1'b1; in_valid = 1'b0;
      cyc();
      @(negedge clk);
      check("t2_valid_clr", 32'(out_valid), 32'd0);
      check("t2_idle_ready", 32'(in_ready), 32'd1);

      // Back-to-back, three ops
      cyc();
      rise_q.delete();
      acc0 = 0;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: begin in_x = 8'h01; in_y = 8'h02; in_m = 2'b00; in_s = 2'b00; end
            1: begin in_x = 8'hFF; in_y = 8'h0F; in_m = 2'b11; in_s = 2'b10; end
            default: begin in_x = 8'hA5; in_y = 8'h00; in_m = 2'b11; in_s = 2'b11; end
         endcase
         in_valid = 1'b1;
         wait_ready(ok);
         check("t3_accept_timeout", 32'(ok), 32'd1);
         cyc();
         if (k == 0) acc0 = edge_cnt;
      end
      in_valid = 1'b0;
      repeat (12) cyc();
      check("t3_result_count", 32'(rise_q.size()), 32'd3);
      if (rise_q.size() == 3) begin
         check("t3_first_lat", 32'(rise_q[0] - acc0), 32'd4);
         check("t3_interval1", 32'(rise_q[1] - rise_q[0]), 32'd5);
         check("t3_interval2", 32'(rise_q[2] - rise_q[1]), 32'd5);
      end

      // Reset during SETTLE with counter at 2
      in_x = 8'h12; in_y = 8'h34; in_m = 2'b11; in_s = 2'b01; in_valid = 1'b1;
      wait_ready(ok);
      check("t4_accept_timeout", 32'(ok), 32'd1);
      cyc();
      in_valid = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("t4_in_ready", 32'(in_ready), 32'd1);
      check("t4_out_valid", 32'(out_valid), 32'd0);
      check("t4_alu_x", 32'(alu_x), 32'd0);
      repeat (8) begin
         cyc();
         @(negedge clk);
         check("t4_no_result", 32'(out_valid), 32'd0);
      end

      // Forced ALU results: negative, then zero
      for (int k = 0; k < 2; k++) begin
         cyc();
         ov_en = 1'b1; ov_val = (k == 0) ? 16'h8000 : 16'h0000;
         in_x = 8'h00; in_y = 8'h00; in_m = 2'b10; in_s = 2'(k); in_valid = 1'b1;
         wait_ready(ok);
         check("t5_accept_timeout", 32'(ok), 32'd1);
         cyc();
         in_valid = 1'b0;
         wait_valid(ok);
         check("t5_valid_timeout", 32'(ok), 32'd1);
         check("t5_out_z", 32'(out_z), (k == 0) ? 32'h8000 : 32'h0000);
`ifdef ALU_SEQ_FLAGS_EN
         check("t5_neg", 32'(out_neg), (k == 0) ? 32'd1 : 32'd0);
         check("t5_zero", 32'(out_zero), (k == 0) ? 32'd0 : 32'd1);
`endif
         cyc();
      end
      cyc();
      ov_en = 1'b0;

      // SETTLE_CYCLES = 1 instance
      zb = 16'h1111; in_valid_b = 1'b1;
      @(negedge clk);
      check("t6_in_ready", 32'(in_ready_b), 32'd1);
      cyc();
      in_valid_b = 1'b0;
      @(negedge clk);
      check("t6_valid_early", 32'(out_valid_b), 32'd0);
      check("t6_alu", 32'({alu_x_b, alu_y_b}), 32'h0102);
      cyc();
      zb = 16'h2222;
      @(negedge clk);
      check("t6_valid", 32'(out_valid_b), 32'd1);
      check("t6_out_z", 32'(out_z_b), 32'h1111);
      check("t6_out_ms", 32'({out_m_b, out_s_b}), 32'b0001);
`ifdef ALU_SEQ_FLAGS_EN
      check("t6_flags", 32'({out_zero_b, out_neg_b}), 32'b00);
`endif
      repeat (3) begin
         cyc();
         @(negedge clk);
         check("t6_out_z_hold", 32'(out_z_b), 32'h1111);
      end
      cyc();
      out_ready_b = 1'b1;
      cyc();
      @(negedge clk);
      check("t6_valid_clr", 32'(out_valid_b), 32'd0);

      repeat (3) cyc();
      check("sb_leftover", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered command front-end and result back-end for the 8-bit ALU datapath. Accepts one operation (operands, mode, select) per valid/ready handshake and drives the registered operands onto the combinational ALU units built from delay gates. It then waits a fixed settle time and captures the 16-bit ALU result into an output register offered downstream with its own valid/ready handshake. It sits between the instruction/operand source and the logic/arithmetic units.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles `alu_z` is allowed to settle after operands change; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  command offered
- in_ready  out  1  command accepted when `in_valid && in_ready` at a rising edge
- in_x  in  8  operand x
- in_y  in  8  operand y
- in_m  in  2  unit mode (2'b11 = logic unit)
- in_s  in  2  operation select within unit
- alu_x  out  8  registered operand x to ALU units
- alu_y  out  8  registered operand y to ALU units
- alu_m  out  2  registered mode to ALU units
- alu_s  out  2  registered select to ALU units
- alu_z  in  16  combinational ALU result
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result when `out_valid && out_ready` at a rising edge
- out_z  out  16  captured result
- out_m, out_s  out  2 each  mode/select of the operation that produced `out_z`
- out_zero  out  1  `out_z == 0` (only with ALU_SEQ_FLAGS_EN)
- out_neg  out  1  `out_z[15]` (only with ALU_SEQ_FLAGS_EN)

## Operation
- FSM states: IDLE, SETTLE, DONE. Reset state IDLE.
- `in_ready = (state == IDLE) || (state == DONE && out_ready)`; combinational from state and `out_ready` only.
- IDLE: on input handshake, load `alu_x/y/m/s` from `in_*`, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: counter decrements each cycle; `in_*` ignored. When counter == 0, capture `alu_z` into `out_z`, copy `alu_m/alu_s` into `out_m/out_s`, set `out_valid`, go to DONE.
- DONE: `out_valid` = 1, `out_z/out_m/out_s` held stable until output handshake.
  - Output handshake, no input handshake: clear `out_valid`, go to IDLE.
  - Output and input handshake in the same cycle: clear `out_valid`, load new operands, reload counter, go to SETTLE (back-to-back).
- `alu_*` hold the last accepted operation in IDLE and DONE; they change only on input handshake or reset.
- Counter width is 4 bits; it never wraps (loaded only on accept, stops at 0).

## Timing
- Reset values: `in_ready` = 1 (IDLE), `out_valid` = 0, `out_z` = 0, `out_m` = 0, `out_s` = 0, `alu_x/y/m/s` = 0, counter = 0, `out_zero` = 1, `out_neg` = 0.
- Input accepted at edge T: `alu_*` show the new values after T. `alu_z` is sampled at edge T+SETTLE_CYCLES. `out_valid` is high from T+SETTLE_CYCLES.
- Minimum issue interval is SETTLE_CYCLES+1 cycles with `out_ready` tied high.
- `out_valid` never drops without an output handshake. `out_z` never changes while `out_valid && !out_ready`.
- Reset asserted in any state returns all registers to reset values at the next edge. An in-flight operation is discarded and no result is produced.
- `in_valid` deasserting or `in_*` changing while `in_ready` = 0 has no effect.

## Configuration
- ALU_SEQ_FLAGS_EN defined:
  - `out_zero` and `out_neg` ports exist.
  - Both are registered at the same edge as `out_z` and held with it.
  - Reset values are 1 and 0.
- Not defined: ports and flag registers are absent. All other behaviour is identical.

## Test plan
- Reset, then single op x=8'hF0, y=8'h3C, m=2'b11, s=2'b00, SETTLE_CYCLES=4, with a model driving `alu_z = {8'h00, x & y}` -> `alu_*` update one edge after accept, `out_valid` rises 4 edges after accept, `out_z` = 16'h0030, `out_zero` = 0.
- Hold `out_ready` = 0 for 10 cycles in DONE while `in_valid` = 1 with new operands -> `out_z` stays 16'h0030, `in_ready` stays 0, `alu_*` unchanged.
- Back-to-back: `out_ready` = 1 and `in_valid` = 1 continuously, 3 ops -> each result valid exactly 5 cycles after the previous one, with no lost or duplicated results.
- Assert `rst` for 1 cycle in SETTLE with counter = 2 -> next cycle IDLE, `out_valid` = 0, `alu_x` = 0, and no result is ever produced for that op.
- Model `alu_z` = 16'h8000 with x=y=0 -> `out_neg` = 1, `out_zero` = 0. Model `alu_z` = 16'h0000 -> `out_zero` = 1 (flags build only).
- SETTLE_CYCLES=1 -> `out_valid` one edge after accept; the model result changing at the second edge after accept is not captured.
